apb4_slave_mem: RTL and testbench
=================================

// Module: apb4_slave_mem
// PURPOSE
//  Parametrised APB4 completer backed by a word-addressed register/memory array.
//  Adds to the basic APB slave signal set: programmable wait states, PSTRB byte-lane writes,
//  PPROT-based secure region, and PSLVERR on bad/forbidden addresses.
//  Sits behind the APB bridge; serves as the reference responder for the APB4 slave VIP.
// PARAMETERS
//  ADDR_WIDTH    32            PADDR width
//  DATA_WIDTH    32            PWDATA/PRDATA width; legal values 8,16,32
//  DEPTH         256           number of DATA_WIDTH words in the array
//  BASE_ADDR     32'h0000_0000 byte address of word 0; must be DEPTH*(DATA_WIDTH/8) aligned
//  SECURE_WORDS  0             words [0..SECURE_WORDS-1] are secure-only; 0 = no secure region
//  WAIT_W        4             width of wait_states input
// PORTS
//  PCLK         in   1                 APB clock
//  PRESETn      in   1                 async active-low reset
//  PSEL         in   1                 completer select
//  PENABLE      in   1                 access phase
//  PWRITE       in   1                 1=write 0=read
//  PADDR        in   ADDR_WIDTH        byte address
//  PWDATA       in   DATA_WIDTH        write data
//  PSTRB        in   DATA_WIDTH/8      write byte strobes
//  PPROT        in   3                 protection; PPROT[1]=1 means non-secure
//  wait_states  in   WAIT_W            wait cycles to insert; sampled in SETUP only
//  PRDATA       out  DATA_WIDTH        read data, valid while PREADY=1 on a read
//  PREADY       out  1                 transfer completion
//  PSLVERR      out  1                 error response, valid while PREADY=1
//  err_count    out  16                saturating count of PSLVERR responses
// BEHAVIOUR
//  Reset (PRESETn=0, async): PRDATA=0, PREADY=0, PSLVERR=0, err_count=0, array cleared to 0, FSM=IDLE.
//  FSM: IDLE -> ACCESS on edge with PSEL=1,PENABLE=0 (setup phase); ACCESS -> IDLE on edge with
//   PREADY=1 (completion) or PSEL=0 (abort). PENABLE=1 seen in IDLE is ignored (no response).
//  At setup edge: capture PADDR/PWRITE/PPROT; cnt<=wait_states; PREADY<=(wait_states==0);
//   decode error; for reads PRDATA<=err?0:mem[idx]; PSLVERR<=err (both held until completion).
//  In ACCESS with PREADY=0: cnt decrements each edge; PREADY<=1 on edge where cnt==1.
//   Zero wait => PREADY=1 in first access cycle (2-cycle transfer); N wait => N low cycles then high.
//  Completion edge (PSEL&PENABLE&PREADY): write commits if !err, lane b updated iff PSTRB[b];
//   PREADY<=0, PSLVERR<=0, PRDATA<=0; err_count+1 (sat at 16'hFFFF) if error.
//  PWDATA/PSTRB sampled at completion edge, not setup.
//  Index idx = (PADDR-BASE_ADDR)>>log2(DATA_WIDTH/8). Error if any of: PADDR<BASE_ADDR;
//   idx>=DEPTH; PADDR low log2(DATA_WIDTH/8) bits nonzero; PPROT[1]=1 and idx<SECURE_WORDS.
//  Write with PSTRB=0: no array change, no error. PSTRB ignored on reads.
//  Abort (PSEL=0 before completion): no write, no error count, PREADY/PSLVERR/PRDATA<=0, IDLE.
//  wait_states changes during ACCESS have no effect on the current transfer.
//  Back-to-back: completion edge -> IDLE; next setup accepted the following cycle.
// TESTING
//  1 wait=0, write 32'hDEADBEEF @BASE+0x10 PSTRB=F, read back -> PREADY=1 1st access cycle, PRDATA=DEADBEEF, PSLVERR=0.
//  2 write 32'h11223344 PSTRB=4'b0101 over DEADBEEF -> read 32'hDE22BE44; PSTRB=0 write -> unchanged.
//  3 wait=3 -> PREADY low 3 access cycles, high 4th; set wait=0 mid-access -> still 3 waits.
//  4 write @BASE+DEPTH*4 and @BASE+0x2 -> PSLVERR=1 with PREADY, array unchanged, err_count=2.
//  5 SECURE_WORDS=4, PPROT=3'b010 read word 0 -> PSLVERR=1, PRDATA=0; PPROT=3'b000 -> OK.
//  6 PRESETn low during wait=5 access -> outputs 0 immediately, array 0; next transfer normal.

Source files
------------

// File: rtl/apb4_slave_mem.sv
// apb4_slave_mem: APB4 completer backed by a word-addressed memory array.
// Supports programmable wait states, PSTRB byte-lane writes, a PPROT-gated
// secure region at the bottom of the array, and PSLVERR on bad addresses.
//
// Handshake: a transfer starts with a setup cycle (PSEL=1, PENABLE=0). The
// requester then holds PSEL=1, PENABLE=1 and all controls stable until it
// samples PREADY=1. That edge (PSEL & PENABLE & PREADY) is the completion
// point: write data and strobes are taken there, and PRDATA/PSLVERR are valid
// in the cycle leading up to it. Dropping PSEL before completion aborts the
// transfer with no side effects.
module apb4_slave_mem #(
    parameter int                    ADDR_WIDTH   = 32,
    parameter int                    DATA_WIDTH   = 32,
    parameter int                    DEPTH        = 256,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR    = '0,
    parameter int                    SECURE_WORDS = 0,
    parameter int                    WAIT_W       = 4
) (
    input  logic                    PCLK,
    input  logic                    PRESETn,
    input  logic                    PSEL,
    input  logic                    PENABLE,
    input  logic                    PWRITE,
    input  logic [ADDR_WIDTH-1:0]   PADDR,
    input  logic [DATA_WIDTH-1:0]   PWDATA,
    input  logic [DATA_WIDTH/8-1:0] PSTRB,
    input  logic [2:0]              PPROT,
    input  logic [WAIT_W-1:0]       wait_states,
    output logic [DATA_WIDTH-1:0]   PRDATA,
    output logic                    PREADY,
    output logic                    PSLVERR,
    output logic [15:0]             err_count
);

    localparam int BYTES = DATA_WIDTH / 8;
    localparam int LSB   = $clog2(BYTES);
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_ACCESS = 1'b1
    } state_e;

    state_e                  state_q, state_d;
    logic [WAIT_W-1:0]       cnt_q, cnt_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic                    write_q, write_d;
    logic [DATA_WIDTH-1:0]   prdata_q, prdata_d;
    logic                    pready_q, pready_d;
    logic                    pslverr_q, pslverr_d;
    logic [15:0]             err_count_q, err_count_d;
    logic [DATA_WIDTH-1:0]   mem_q [DEPTH];
    logic [DATA_WIDTH-1:0]   mem_d [DEPTH];

    // Address decode of the live bus address, used only at the setup edge.
    logic [ADDR_WIDTH-1:0] addr_off;
    logic [ADDR_WIDTH-1:0] full_idx;
    logic                  below_base;
    logic                  out_of_range;
    logic                  misaligned;
    logic                  secure_hit;
    logic                  addr_err;

    assign addr_off     = PADDR - BASE_ADDR;
    assign full_idx     = addr_off >> LSB;
    assign out_of_range = (full_idx >= ADDR_WIDTH'(DEPTH));
    assign misaligned   = ((PADDR & ADDR_WIDTH'(BYTES - 1)) != '0);
    assign addr_err     = below_base | out_of_range | misaligned | secure_hit;

    // A zero base or empty secure region makes these compares constant; skip them.
    if (BASE_ADDR != '0) begin : g_base_chk
        assign below_base = (PADDR < BASE_ADDR);
    end else begin : g_no_base_chk
        assign below_base = 1'b0;
    end

    if (SECURE_WORDS > 0) begin : g_secure
        assign secure_hit = PPROT[1] & (full_idx < ADDR_WIDTH'(SECURE_WORDS));
    end else begin : g_no_secure
        assign secure_hit = 1'b0;
    end

    // Next-state, response and memory-update logic for the two-state transfer FSM.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        idx_d       = idx_q;
        write_d     = write_q;
        prdata_d    = prdata_q;
        pready_d    = pready_q;
        pslverr_d   = pslverr_q;
        err_count_d = err_count_q;
        mem_d       = mem_q;

        case (state_q)
            ST_IDLE: begin
                // PENABLE=1 without a preceding setup cycle gets no response.
                if (PSEL && !PENABLE) begin
                    state_d   = ST_ACCESS;
                    cnt_d     = wait_states;
                    pready_d  = (wait_states == '0);
                    idx_d     = full_idx[IDX_W-1:0];
                    write_d   = PWRITE;
                    pslverr_d = addr_err;
                    if (!PWRITE) begin
                        prdata_d = addr_err ? '0 : mem_q[full_idx[IDX_W-1:0]];
                    end
                end
            end

            ST_ACCESS: begin
                if (!PSEL) begin
                    // Abort: drop everything, no write, no error accounting.
                    state_d   = ST_IDLE;
                    pready_d  = 1'b0;
                    pslverr_d = 1'b0;
                    prdata_d  = '0;
                end else if (pready_q) begin
                    state_d   = ST_IDLE;
                    pready_d  = 1'b0;
                    pslverr_d = 1'b0;
                    prdata_d  = '0;
                    if (PENABLE) begin
                        if (pslverr_q) begin
                            if (err_count_q != 16'hFFFF) begin
                                err_count_d = err_count_q + 16'd1;
                            end
                        end else if (write_q) begin
                            for (int b = 0; b < BYTES; b++) begin
                                if (PSTRB[b]) begin
                                    mem_d[idx_q][8*b +: 8] = PWDATA[8*b +: 8];
                                end
                            end
                        end
                    end
                end else begin
                    // Wait count was latched at setup; later wait_states changes are ignored.
                    cnt_d = cnt_q - 1'b1;
                    if (cnt_q == WAIT_W'(1)) begin
                        pready_d = 1'b1;
                    end
                end
            end

            default: state_d = ST_IDLE;
        endcase
    end

    // State, response and memory registers; async reset clears the whole array.
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            idx_q       <= '0;
            write_q     <= 1'b0;
            prdata_q    <= '0;
            pready_q    <= 1'b0;
            pslverr_q   <= 1'b0;
            err_count_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            idx_q       <= idx_d;
            write_q     <= write_d;
            prdata_q    <= prdata_d;
            pready_q    <= pready_d;
            pslverr_q   <= pslverr_d;
            err_count_q <= err_count_d;
            mem_q       <= mem_d;
        end
    end

    assign PRDATA    = prdata_q;
    assign PREADY    = pready_q;
    assign PSLVERR   = pslverr_q;
    assign err_count = err_count_q;

endmodule

// File: tb/tb_apb4_slave_mem.sv
// tb_apb4_slave_mem: self-checking bench for apb4_slave_mem with a reference
// memory model and an expected-response queue.
module tb_apb4_slave_mem;

    localparam int          AW    = 32;
    localparam int          DW    = 32;
    localparam int          DEPTH = 256;
    localparam logic [31:0] BASE  = 32'h0000_1000;
    localparam int          SW    = 4;
    localparam int          WW    = 4;
    // Expected entry: {is_read, waits[7:0], err, data[31:0]}
    localparam int          W     = 42;

    logic          PCLK;
    logic          PRESETn;
    logic          PSEL;
    logic          PENABLE;
    logic          PWRITE;
    logic [AW-1:0] PADDR;
    logic [DW-1:0] PWDATA;
    logic [3:0]    PSTRB;
    logic [2:0]    PPROT;
    logic [WW-1:0] wait_states;
    logic [DW-1:0] PRDATA;
    logic          PREADY;
    logic          PSLVERR;
    logic [15:0]   err_count;

    int tests_run    = 0;
    int tests_failed = 0;

    logic [W-1:0]  exp_q[$];
    logic [31:0]   exp_mem [DEPTH];
    logic [15:0]   exp_err_cnt;

    apb4_slave_mem #(
        .ADDR_WIDTH  (AW),
        .DATA_WIDTH  (DW),
        .DEPTH       (DEPTH),
        .BASE_ADDR   (BASE),
        .SECURE_WORDS(SW),
        .WAIT_W      (WW)
    ) dut (
        .PCLK       (PCLK),
        .PRESETn    (PRESETn),
        .PSEL       (PSEL),
        .PENABLE    (PENABLE),
        .PWRITE     (PWRITE),
        .PADDR      (PADDR),
        .PWDATA     (PWDATA),
        .PSTRB      (PSTRB),
        .PPROT      (PPROT),
        .wait_states(wait_states),
        .PRDATA     (PRDATA),
        .PREADY     (PREADY),
        .PSLVERR    (PSLVERR),
        .err_count  (err_count)
    );

    // Clock and reset block
    initial begin
        PCLK = 1'b0;
        forever #5 PCLK = ~PCLK;
    end

    // ---------------- reference model ----------------
    function automatic logic model_err(input logic [31:0] a, input logic [2:0] p);
        logic [31:0] off;
        if (a < BASE) return 1'b1;
        off = a - BASE;
        if ((off >> 2) >= DEPTH) return 1'b1;
        if (a[1:0] != 2'b00) return 1'b1;
        if (p[1] && ((off >> 2) < SW)) return 1'b1;
        return 1'b0;
    endfunction

    task automatic model_clear();
        for (int i = 0; i < DEPTH; i++) exp_mem[i] = 32'h0;
        exp_err_cnt = 16'h0;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        tests_run++;
        if (act !== req) begin
            tests_failed++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    // ---------------- driver ----------------
    task automatic bus_idle();
        @(negedge PCLK);
        PSEL = 1'b0; PENABLE = 1'b0;
    endtask

    // One full APB transfer. Expectations are pushed at setup and popped at completion.
    task automatic apb_xfer(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                            input logic [3:0] strb, input logic [2:0] prot, input int ws);
        logic        err;
        logic [31:0] idx;
        logic [31:0] edata;
        logic [W-1:0] e;
        int          waits;
        err   = model_err(addr, prot);
        idx   = (addr - BASE) >> 2;
        edata = 32'h0;
        if (!wr && !err) edata = exp_mem[idx[7:0]];
        exp_q.push_back({~wr, 8'(ws), err, edata});
        if (err) begin
            if (exp_err_cnt != 16'hFFFF) exp_err_cnt = exp_err_cnt + 16'd1;
        end else if (wr) begin
            for (int b = 0; b < 4; b++)
                if (strb[b]) exp_mem[idx[7:0]][8*b +: 8] = wdata[8*b +: 8];
        end

        // Setup phase; write data deliberately wrong here, valid only in access.
        @(negedge PCLK);
        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = wr; PADDR = addr; PPROT = prot;
        wait_states = WW'(ws); PWDATA = ~wdata; PSTRB = ~strb;
        // Access phase; wait_states changes here must not matter.
        @(negedge PCLK);
        PENABLE = 1'b1; PWDATA = wdata; PSTRB = strb; wait_states = '0;
        waits = 0;
        while (PREADY !== 1'b1 && waits < 64) begin
            @(negedge PCLK);
            waits++;
        end
        e = exp_q.pop_front();
        tests_run++;
        if (waits >= 64) begin
            tests_failed++;
            $display("FAIL xfer_timeout addr=%h: PREADY never rose", addr);
        end else begin
            check("wait_cycles", 32'(waits), 32'(e[40:33]));
            check("pslverr", {31'h0, PSLVERR}, {31'h0, e[32]});
            if (e[41]) check("prdata", PRDATA, e[31:0]);
        end
    endtask

    // ---------------- scenario tasks ----------------
    task automatic test_reset();
        PSEL = 0; PENABLE = 0; PWRITE = 0; PADDR = 0; PWDATA = 0; PSTRB = 0;
        PPROT = 0; wait_states = 0; PRESETn = 1'b1;
        model_clear();
        repeat (2) @(negedge PCLK);
        PRESETn = 1'b0;
        #1;
        check("rst_prdata", PRDATA, 32'h0);
        check("rst_pready", {31'h0, PREADY}, 32'h0);
        check("rst_pslverr", {31'h0, PSLVERR}, 32'h0);
        check("rst_err_count", {16'h0, err_count}, 32'h0);
        repeat (2) @(negedge PCLK);
        PRESETn = 1'b1;
    endtask

    task automatic test_basic();
        apb_xfer(1, BASE + 32'h10, 32'hDEADBEEF, 4'hF, 3'b000, 0);
        apb_xfer(0, BASE + 32'h10, 32'h0, 4'h0, 3'b000, 0);
        bus_idle();
    endtask

    task automatic test_strobes();
        apb_xfer(1, BASE + 32'h10, 32'h11223344, 4'b0101, 3'b000, 0);
        apb_xfer(0, BASE + 32'h10, 32'h0, 4'h0, 3'b000, 0);
        check("strobe_model", exp_mem[4], 32'hDE22BE44);
        apb_xfer(1, BASE + 32'h10, 32'h55667788, 4'b0000, 3'b000, 0);
        apb_xfer(0, BASE + 32'h10, 32'h0, 4'hF, 3'b000, 0);
        bus_idle();
    endtask

    task automatic test_wait_states();
        apb_xfer(1, BASE + 32'h20, 32'hA5A5_0F0F, 4'hF, 3'b000, 3);
        apb_xfer(0, BASE + 32'h20, 32'h0, 4'h0, 3'b000, 3);
        apb_xfer(0, BASE + 32'h20, 32'h0, 4'h0, 3'b000, 15);
        bus_idle();
    endtask

    task automatic test_errors();
        apb_xfer(1, BASE + DEPTH * 4, 32'h1234_5678, 4'hF, 3'b000, 0);
        apb_xfer(1, BASE + 32'h2, 32'h1234_5678, 4'hF, 3'b000, 1);
        bus_idle();
        @(negedge PCLK);
        check("err_count_two", {16'h0, err_count}, 32'(exp_err_cnt));
        apb_xfer(0, BASE + 32'h0, 32'h0, 4'h0, 3'b000, 0);
        apb_xfer(0, BASE + 32'h2, 32'h0, 4'h0, 3'b000, 0);
        apb_xfer(1, BASE - 32'h4, 32'hFFFF_FFFF, 4'hF, 3'b000, 0);
        bus_idle();
        @(negedge PCLK);
        check("err_count_more", {16'h0, err_count}, 32'(exp_err_cnt));
    endtask

    task automatic test_secure();
        apb_xfer(1, BASE + 32'h0, 32'hCAFE_F00D, 4'hF, 3'b000, 0);
        apb_xfer(0, BASE + 32'h0, 32'h0, 4'h0, 3'b010, 0);
        apb_xfer(0, BASE + 32'h0, 32'h0, 4'h0, 3'b000, 0);
        apb_xfer(1, BASE + 32'hC, 32'h0BAD_0BAD, 4'hF, 3'b010, 1);
        apb_xfer(0, BASE + 32'hC, 32'h0, 4'h0, 3'b000, 0);
        apb_xfer(0, BASE + 32'h10, 32'h0, 4'h0, 3'b010, 0);
        bus_idle();
    endtask

    task automatic test_idle_penable();
        @(negedge PCLK);
        PSEL = 1'b1; PENABLE = 1'b1; PWRITE = 1'b0; PADDR = BASE + 32'h10; wait_states = '0;
        for (int i = 0; i < 3; i++) begin
            @(negedge PCLK);
            check("idle_penable_pready", {31'h0, PREADY}, 32'h0);
        end
        bus_idle();
    endtask

    task automatic test_abort();
        logic [31:0] addrs [2];
        addrs[0] = BASE + 32'h14;
        addrs[1] = BASE + 32'h15;
        for (int k = 0; k < 2; k++) begin
            @(negedge PCLK);
            PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = addrs[k];
            PPROT = 3'b000; wait_states = 4'd3; PWDATA = 32'h7777_7777; PSTRB = 4'hF;
            @(negedge PCLK);
            PENABLE = 1'b1;
            @(negedge PCLK);
            PSEL = 1'b0; PENABLE = 1'b0;
            @(negedge PCLK);
            check("abort_pready", {31'h0, PREADY}, 32'h0);
            check("abort_pslverr", {31'h0, PSLVERR}, 32'h0);
            check("abort_err_count", {16'h0, err_count}, 32'(exp_err_cnt));
        end
        apb_xfer(0, BASE + 32'h14, 32'h0, 4'h0, 3'b000, 0);
        bus_idle();
    endtask

    task automatic test_back_to_back();
        logic        wr;
        logic [31:0] addr;
        logic [2:0]  prot;
        for (int i = 0; i < 24; i++) begin
            wr   = 1'($urandom_range(0, 1));
            addr = BASE + 32'($urandom_range(0, 15)) * 4;
            if ($urandom_range(0, 7) == 0) addr = addr + 32'h1;
            prot = ($urandom_range(0, 3) == 0) ? 3'b010 : 3'b000;
            apb_xfer(wr, addr, $urandom, 4'($urandom_range(0, 15)), prot, $urandom_range(0, 2));
        end
        bus_idle();
        @(negedge PCLK);
        check("b2b_err_count", {16'h0, err_count}, 32'(exp_err_cnt));
    endtask

    task automatic test_reset_mid();
        @(negedge PCLK);
        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = BASE + 32'h10;
        PPROT = 3'b000; wait_states = 4'd5; PWDATA = 32'h1357_9BDF; PSTRB = 4'hF;
        @(negedge PCLK);
        PENABLE = 1'b1;
        repeat (2) @(negedge PCLK);
        PRESETn = 1'b0;
        PSEL = 1'b0; PENABLE = 1'b0;
        #1;
        model_clear();
        check("rstmid_pready", {31'h0, PREADY}, 32'h0);
        check("rstmid_pslverr", {31'h0, PSLVERR}, 32'h0);
        check("rstmid_prdata", PRDATA, 32'h0);
        check("rstmid_err_count", {16'h0, err_count}, 32'h0);
        repeat (2) @(negedge PCLK);
        PRESETn = 1'b1;
        apb_xfer(0, BASE + 32'h10, 32'h0, 4'h0, 3'b000, 0);
        apb_xfer(0, BASE + 32'h0, 32'h0, 4'h0, 3'b000, 0);
        apb_xfer(1, BASE + 32'h40, 32'h2468_ACE0, 4'hF, 3'b000, 1);
        apb_xfer(0, BASE + 32'h40, 32'h0, 4'h0, 3'b000, 0);
        bus_idle();
    endtask

    // Test sequence and final report
    initial begin
        test_reset();
        test_basic();
        test_strobes();
        test_wait_states();
        test_errors();
        test_secure();
        test_idle_penable();
        test_abort();
        test_back_to_back();
        test_reset_mid();
        tests_run++;
        if (exp_q.size() != 0) begin
            tests_failed++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    // Global watchdog so the run always terminates.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed + 1);
        $fatal(1, "watchdog");
    end

endmodule
